// File: rtl/spawn_scheduler.sv
// Spawn request scheduler: paces spawn requests by max(gene_time, MIN_INTERVAL)
// cycles, counts acknowledged spawns and pulses levelup every SPAWNS_PER_LEVEL of them.
module spawn_scheduler #(
  parameter int unsigned SPAWNS_PER_LEVEL = 16,
  parameter int unsigned MIN_INTERVAL     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        pause,
  input  logic [31:0] gene_time,
  input  logic        spawn_ack,
  output logic        spawn_req,
  output logic        levelup,
  output logic [15:0] spawn_count,
  output logic [1:0]  state
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] COUNT = 2'b01;
  localparam logic [1:0] REQ   = 2'b10;

  localparam logic [31:0] MIN_N      = 32'(MIN_INTERVAL);
  localparam logic [15:0] LEVEL_LAST = 16'(SPAWNS_PER_LEVEL - 1);

  logic [31:0] n_eff;
  logic [31:0] n_last;
  logic [31:0] timer;
  logic [31:0] timer_nxt;
  logic [1:0]  state_nxt;
  logic [15:0] level_cnt;
  logic        ack_take;

  // The interval is re-evaluated every cycle so a gene_time change applies mid-count.
  assign n_eff    = (gene_time < MIN_N) ? MIN_N : gene_time;
  assign n_last   = n_eff - 32'd1;
  assign ack_take = enable && (state == REQ) && spawn_ack;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    if (!enable) begin
      state_nxt = IDLE;
      timer_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = COUNT;
          timer_nxt = '0;
        end
        COUNT: begin
          if (!pause) begin
            if (timer >= n_last) begin
              state_nxt = REQ;
              timer_nxt = '0;
            end else begin
              timer_nxt = timer + 32'd1;
            end
          end
        end
        REQ: begin
          if (spawn_ack) begin
            state_nxt = COUNT;
            timer_nxt = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      timer       <= '0;
      spawn_req   <= 1'b0;
      levelup     <= 1'b0;
      spawn_count <= '0;
      level_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      spawn_req <= (state_nxt == REQ);
      levelup   <= 1'b0;
      if (ack_take) begin
        spawn_count <= spawn_count + 16'd1;
        if (level_cnt == LEVEL_LAST) begin
          level_cnt <= '0;
          levelup   <= 1'b1;
        end else begin
          level_cnt <= level_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spawn_scheduler.sv
// Scoreboard bench for spawn_scheduler: stimulus queues expected request/levelup
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_spawn_scheduler;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_COUNT = 2'b01;
  localparam logic [1:0] S_REQ   = 2'b10;

  typedef struct {
    int          cyc;
    logic [15:0] cnt;
  } req_exp_t;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        pause;
  logic [31:0] gene_time;
  logic        spawn_ack;
  logic        spawn_req;
  logic        levelup;
  logic [15:0] spawn_count;
  logic [1:0]  state;

  int          cyc;
  int          n_cmp;
  int          n_bad;
  req_exp_t    req_q[$];
  int          lvl_q[$];
  logic [15:0] exp_cnt;
  int          exp_lvl;
  logic        prev_req;

  spawn_scheduler #(
    .SPAWNS_PER_LEVEL(3),
    .MIN_INTERVAL    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .pause      (pause),
    .gene_time  (gene_time),
    .spawn_ack  (spawn_ack),
    .spawn_req  (spawn_req),
    .levelup    (levelup),
    .spawn_count(spawn_count),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Returns just after the rising edge that makes cyc == c.
  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One request/ack round: COUNT entered at edge e, request expected n cycles later,
  // ack returned two cycles after the request, gene_time switched to gt_next with the ack.
  task automatic do_spawn(input int e, input int n, input int pause_at, input int pause_len,
                          input logic [31:0] gt_next, input bit pause_in_req, output int next_e);
    int r;
    r = e + n;
    req_q.push_back('{r, exp_cnt});
    if (pause_len > 0) begin
      wait_to(e + pause_at);
      pause = 1'b1;
      wait_to(e + pause_at + pause_len);
      pause = 1'b0;
    end
    wait_to(r);
    check("state_in_req", 32'(state), 32'(S_REQ));
    if (pause_in_req) pause = 1'b1;
    wait_to(r + 2);
    check("req_held", 32'(spawn_req), 32'd1);
    pause     = 1'b0;
    spawn_ack = 1'b1;
    gene_time = gt_next;
    wait_to(r + 3);
    spawn_ack = 1'b0;
    exp_cnt   = exp_cnt + 16'd1;
    exp_lvl++;
    if (exp_lvl == 3) begin
      lvl_q.push_back(r + 3);
      exp_lvl = 0;
    end
    check("state_after_ack", 32'(state), 32'(S_COUNT));
    check("count_after_ack", 32'(spawn_count), 32'(exp_cnt));
    next_e = r + 3;
  endtask

  // Monitor: compares each request rise and each levelup cycle against the queues.
  initial prev_req = 1'b0;
  always @(negedge clk) begin
    if (spawn_req && !prev_req) begin
      if (req_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_req: rise at cycle %0d with nothing expected", cyc);
      end else begin
        req_exp_t x;
        x = req_q.pop_front();
        check("req_rise_cycle", 32'(cyc), 32'(x.cyc));
        check("req_rise_count", 32'(spawn_count), 32'(x.cnt));
      end
    end
    if (levelup) begin
      if (lvl_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_levelup: pulse at cycle %0d with nothing expected", cyc);
      end else begin
        check("levelup_cycle", 32'(cyc), 32'(lvl_q.pop_front()));
      end
    end
    prev_req <= spawn_req;
  end

  initial begin
    int e;
    n_cmp     = 0;
    n_bad     = 0;
    exp_cnt   = 16'd0;
    exp_lvl   = 0;
    rst       = 1'b0;
    enable    = 1'b0;
    pause     = 1'b0;
    gene_time = 32'd0;
    spawn_ack = 1'b0;

    #2;
    check("rst_state", 32'(state), 32'(S_IDLE));
    check("rst_req", 32'(spawn_req), 32'd0);
    check("rst_levelup", 32'(levelup), 32'd0);
    check("rst_count", 32'(spawn_count), 32'd0);
    #10 rst = 1'b1;

    // Nominal pacing with gene_time=10, then the MIN_INTERVAL floor.
    wait_to(3);
    check("idle_before_enable", 32'(state), 32'(S_IDLE));
    enable    = 1'b1;
    gene_time = 32'd10;
    wait_to(4);
    check("count_entry", 32'(state), 32'(S_COUNT));
    do_spawn(4, 10, 0, 0, 32'd10, 1'b0, e);
    do_spawn(e, 10, 0, 0, 32'd2, 1'b0, e);
    do_spawn(e, 4, 0, 0, 32'd10, 1'b0, e);

    // Five-cycle pause mid-count, then pause held during REQ.
    do_spawn(e, 15, 4, 5, 32'd4, 1'b1, e);
    do_spawn(e, 4, 0, 0, 32'd4, 1'b0, e);
    do_spawn(e, 4, 0, 0, 32'd100, 1'b0, e);
    check("count_six", 32'(spawn_count), 32'd6);

    // gene_time 100 -> 5 with timer at 20: REQ on the very next edge.
    req_q.push_back('{e + 21, exp_cnt});
    wait_to(e + 20);
    gene_time = 32'd5;
    wait_to(e + 21);
    check("shrink_state", 32'(state), 32'(S_REQ));
    wait_to(e + 23);
    enable    = 1'b0;
    spawn_ack = 1'b1;
    wait_to(e + 24);
    check("disable_state", 32'(state), 32'(S_IDLE));
    check("disable_req", 32'(spawn_req), 32'd0);
    check("disable_count", 32'(spawn_count), 32'(exp_cnt));

    // Ack held through IDLE and early COUNT must be ignored.
    wait_to(e + 26);
    check("idle_ack_count", 32'(spawn_count), 32'(exp_cnt));
    enable = 1'b1;
    wait_to(e + 29);
    check("count_ack_state", 32'(state), 32'(S_COUNT));
    check("count_ack_count", 32'(spawn_count), 32'(exp_cnt));
    spawn_ack = 1'b0;
    do_spawn(e + 27, 5, 0, 0, 32'd5, 1'b0, e);

    // Asynchronous reset between edges while a request is pending.
    req_q.push_back('{e + 5, exp_cnt});
    wait_to(e + 6);
    #2 rst = 1'b0;
    #1;
    check("async_rst_req", 32'(spawn_req), 32'd0);
    check("async_rst_state", 32'(state), 32'(S_IDLE));
    check("async_rst_count", 32'(spawn_count), 32'd0);
    check("async_rst_levelup", 32'(levelup), 32'd0);
    exp_cnt = 16'd0;
    exp_lvl = 0;
    #4 rst = 1'b1;
    e = e + 7;
    wait_to(e);
    check("post_rst_state", 32'(state), 32'(S_COUNT));
    do_spawn(e, 5, 0, 0, 32'd5, 1'b0, e);
    do_spawn(e, 5, 0, 0, 32'd5, 1'b0, e);
    do_spawn(e, 5, 0, 0, 32'd5, 1'b0, e);

    enable = 1'b0;
    wait_to(e + 4);
    check("req_q_drained", 32'(req_q.size()), 32'd0);
    check("lvl_q_drained", 32'(lvl_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
